// File: rtl/ifc_arb_pkg.sv
// Shared types and defaults for the register-interface round-robin arbiter.
package ifc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int DEF_AW      = 3;
  localparam int CNT_W       = 8;
  localparam int DEF_TIMEOUT = 16;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ifc_rr_arb.sv
// Combinational round-robin picker: the first valid requester found by
// searching upward from rr, wrapping modulo NREQ. Grant is one-hot or zero.
module ifc_rr_arb
  import ifc_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IW-1:0]   rr,
  output logic [NREQ-1:0] grant
);

  logic [IW-1:0] pos;
  logic          found;

  // Walk the requesters in priority order starting at rr; first hit wins.
  always_comb begin
    grant = '0;
    pos   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pos = IW'((int'(rr) + i) % NREQ);
      if (!found && req_valid[pos]) begin
        grant[pos] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ifc_arbiter.sv
// Round-robin arbiter sharing the single-port 8x1 register interface between
// NREQ requesters. One command in flight at a time: IDLE grants and latches a
// command, ISSUE drives the dut port until its rdy, RESP holds the response
// until the owner consumes it.
// Optional feature: define IFC_ARB_TIMEOUT_EN to abort a command whose rdy
// stays low for TIMEOUT cycles in ISSUE (response flagged with rsp_err).
module ifc_arbiter
  import ifc_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int AW      = DEF_AW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ-1:0]  req_write,
  input  logic [AW*NREQ-1:0] req_addr,
  input  logic [NREQ-1:0]  req_wdata,
  output logic [NREQ-1:0]  req_ready,
  output logic [NREQ-1:0]  rsp_valid,
  output logic             rsp_data,
  output logic             rsp_err,
  input  logic [NREQ-1:0]  rsp_ready,
  output logic [AW-1:0]    write_address,
  output logic             write_data,
  output logic             write_en,
  input  logic             write_rdy,
  output logic [AW-1:0]    read_address,
  output logic             read_en,
  input  logic             read_data,
  input  logic             read_rdy
);

  localparam int IW = idx_w(NREQ);

  state_t          state;
  state_t          next_state;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   rr;
  logic [IW-1:0]   owner;
  logic            wr_q;
  logic [AW-1:0]   addr_q;
  logic            wdata_q;
  logic            rsp_data_q;
  logic            accept;
  logic            done;
  logic            stall_hit;

  ifc_rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arb (
    .req_valid (req_valid),
    .rr        (rr),
    .grant     (grant)
  );

  // Encode the one-hot grant into an index for latching and rr update.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_idx = IW'(i);
    end
  end

  assign accept = (state == IDLE) && (|grant);
  assign done   = (state == ISSUE) && (wr_q ? write_rdy : read_rdy);

`ifdef IFC_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic             rsp_err_q;

  // The last stalled cycle before the limit aborts the command instead of
  // counting further; a rdy arriving in that same cycle still wins.
  assign stall_hit = (state == ISSUE) && !done &&
                     (stall_cnt == CNT_W'(TIMEOUT - 1));

  // Stall counter and abort flag, both restarted by each accept.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (accept) begin
        stall_cnt <= '0;
        rsp_err_q <= 1'b0;
      end else if ((state == ISSUE) && !done) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (stall_hit) rsp_err_q <= 1'b1;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign stall_hit = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: one command at a time, no grant outside IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = ISSUE;
      ISSUE:   if (done || stall_hit) next_state = RESP;
      RESP:    if (rsp_ready[owner]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs. req_ready is also masked by RST so that a requester
  // holding valid through reset never sees a grant while reset is applied.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    write_en  = 1'b0;
    read_en   = 1'b0;
    case (state)
      IDLE:    if (!RST) req_ready = grant;
      ISSUE: begin
        write_en = wr_q && write_rdy;
        read_en  = !wr_q && read_rdy;
      end
      RESP:    rsp_valid[owner] = 1'b1;
      default: ;
    endcase
  end

  // Command latch, round-robin pointer and response data register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      owner      <= '0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 1'b0;
      rr         <= '0;
      rsp_data_q <= 1'b0;
    end else begin
      if (accept) begin
        owner   <= grant_idx;
        wr_q    <= req_write[grant_idx];
        addr_q  <= req_addr[AW*grant_idx +: AW];
        wdata_q <= req_wdata[grant_idx];
        rr      <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (done)      rsp_data_q <= wr_q ? 1'b0 : read_data;
      if (stall_hit) rsp_data_q <= 1'b0;
    end
  end

  assign write_address = addr_q;
  assign read_address  = addr_q;
  assign write_data    = wdata_q;
  assign rsp_data      = rsp_data_q;

endmodule

// File: tb/tb_ifc_arbiter.sv
// Directed bench for ifc_arbiter (NREQ=2, AW=3). Models the 8x1 register
// behind the dut port; expectations under IFC_ARB_TIMEOUT_EN follow the macro.
module tb_ifc_arbiter;

  logic       CLK;
  logic       RST;
  logic [1:0] req_valid;
  logic [1:0] req_write;
  logic [5:0] req_addr;
  logic [1:0] req_wdata;
  logic [1:0] req_ready;
  logic [1:0] rsp_valid;
  logic       rsp_data;
  logic       rsp_err;
  logic [1:0] rsp_ready;
  logic [2:0] write_address;
  logic       write_data;
  logic       write_en;
  logic       write_rdy;
  logic [2:0] read_address;
  logic       read_en;
  logic       read_data;
  logic       read_rdy;

  logic [7:0] mem;
  int n_chk  = 0;
  int n_fail = 0;

  ifc_arbiter #(.NREQ(2), .AW(3), .TIMEOUT(16)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .rsp_ready     (rsp_ready),
    .write_address (write_address),
    .write_data    (write_data),
    .write_en      (write_en),
    .write_rdy     (write_rdy),
    .read_address  (read_address),
    .read_en       (read_en),
    .read_data     (read_data),
    .read_rdy      (read_rdy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register file behind the dut port; address 2 preloaded to 1.
  always @(posedge CLK or posedge RST) begin
    if (RST) mem <= 8'b0000_0100;
    else if (write_en) mem[write_address] <= write_data;
  end
  assign read_data = mem[read_address];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 32'({req_ready, rsp_valid, rsp_data, rsp_err, write_en, read_en,
                  write_address, read_address, write_data}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int o;
    RST       = 1'b1;
    req_valid = 2'b11;
    req_write = 2'b00;
    req_addr  = {3'd2, 3'd1};
    req_wdata = 2'b00;
    rsp_ready = 2'b11;
    write_rdy = 1'b1;
    read_rdy  = 1'b1;

    // Reset state, with both requesters already asking.
    #12;
    chk_zero("reset_outputs");
    @(negedge CLK);
    RST = 1'b0;
    settle();

    // Both requesters reading, valid held: grants alternate 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      o = k % 2;
      settle();
      chk("rr_ready", 32'(req_ready), 32'(1 << o));
      tick();
      chk("rr_read_en", 32'(read_en), 32'd1);
      chk("rr_read_addr", 32'(read_address), (o == 0) ? 32'd1 : 32'd2);
      tick();
      chk("rr_rsp_valid", 32'(rsp_valid), 32'(1 << o));
      chk("rr_rsp_data", 32'(rsp_data), (o == 0) ? 32'd0 : 32'd1);
      chk("rr_rsp_err", 32'(rsp_err), 32'd0);
      tick();
    end
    req_valid = 2'b00;

    // Req0 writes addr 5 with 1, then reads it back.
    req_valid = 2'b01;
    req_write = 2'b01;
    req_addr  = {3'd2, 3'd5};
    req_wdata = 2'b01;
    settle();
    chk("wr_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    settle();
    chk("wr_en", 32'(write_en), 32'd1);
    chk("wr_addr", 32'(write_address), 32'd5);
    chk("wr_data", 32'(write_data), 32'd1);
    chk("wr_no_read_en", 32'(read_en), 32'd0);
    tick();
    chk("wr_en_pulse", 32'(write_en), 32'd0);
    chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_rsp_data", 32'(rsp_data), 32'd0);
    tick();
    chk("wr_rsp_done", 32'(rsp_valid), 32'd0);
    req_valid = 2'b01;
    req_write = 2'b00;
    settle();
    chk("rd_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    settle();
    chk("rd_en", 32'(read_en), 32'd1);
    chk("rd_addr", 32'(read_address), 32'd5);
    chk("rd_no_write_en", 32'(write_en), 32'd0);
    tick();
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_data", 32'(rsp_data), 32'd1);
    chk("rd_rsp_err", 32'(rsp_err), 32'd0);
    tick();

    // read_rdy low for 3 ISSUE cycles.
    req_valid = 2'b10;
    read_rdy  = 1'b0;
    settle();
    chk("stall_ready", 32'(req_ready), 32'd2);
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_read_en_low", 32'(read_en), 32'd0);
      tick();
    end
    read_rdy = 1'b1;
    settle();
    chk("stall_read_en", 32'(read_en), 32'd1);
    tick();
    chk("stall_rsp_valid", 32'(rsp_valid), 32'd2);
    chk("stall_rsp_data", 32'(rsp_data), 32'd1);
    tick();

    // rsp_ready[1] held low 5 cycles while req0 waits.
    req_valid = 2'b10;
    settle();
    chk("bp_ready1", 32'(req_ready), 32'd2);
    tick();
    req_valid = 2'b11;
    req_addr  = {3'd2, 3'd1};
    rsp_ready = 2'b01;
    settle();
    chk("bp_read_en", 32'(read_en), 32'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("bp_rsp_hold", 32'(rsp_valid), 32'd2);
      chk("bp_data_hold", 32'(rsp_data), 32'd1);
      chk("bp_no_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 2'b11;
    settle();
    chk("bp_release", 32'(rsp_valid), 32'd2);
    tick();
    chk("bp_ready0", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    settle();
    chk("bp_r0_read_addr", 32'(read_address), 32'd1);
    tick();
    chk("bp_r0_rsp", 32'(rsp_valid), 32'd1);
    chk("bp_r0_data", 32'(rsp_data), 32'd0);
    tick();

    // write_rdy low for 16 ISSUE cycles.
    req_valid = 2'b01;
    req_write = 2'b01;
    req_addr  = {3'd2, 3'd3};
    req_wdata = 2'b01;
    write_rdy = 1'b0;
    settle();
    chk("to_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 16; i++) begin
      settle();
      chk("to_write_en_low", 32'(write_en), 32'd0);
      tick();
    end
`ifdef IFC_ARB_TIMEOUT_EN
    chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("to_rsp_err", 32'(rsp_err), 32'd1);
    chk("to_rsp_data", 32'(rsp_data), 32'd0);
    write_rdy = 1'b1;
    settle();
    chk("to_no_write_en", 32'(write_en), 32'd0);
    tick();
    chk("to_mem_untouched", 32'(mem[3]), 32'd0);
`else
    chk("wait_no_rsp", 32'(rsp_valid), 32'd0);
    write_rdy = 1'b1;
    settle();
    chk("wait_write_en", 32'(write_en), 32'd1);
    chk("wait_write_addr", 32'(write_address), 32'd3);
    tick();
    chk("wait_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wait_rsp_err", 32'(rsp_err), 32'd0);
    tick();
    chk("wait_mem_written", 32'(mem[3]), 32'd1);
`endif

    // Reset pulsed mid-ISSUE.
    req_valid = 2'b10;
    req_write = 2'b00;
    req_addr  = {3'd2, 3'd1};
    read_rdy  = 1'b0;
    settle();
    chk("rst_ready1", 32'(req_ready), 32'd2);
    tick();
    req_valid = 2'b11;
    settle();
    chk("rst_issue_addr", 32'(read_address), 32'd2);
    RST = 1'b1;
    #1;
    chk_zero("rst_async_outputs");
    read_rdy = 1'b1;
    tick();
    chk("rst_no_read_en", 32'(read_en), 32'd0);
    chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
    RST = 1'b0;
    settle();
    chk("rst_regrant0", 32'(req_ready), 32'd1);
    tick();
    req_valid = 2'b00;
    settle();
    chk("rst_r0_read_en", 32'(read_en), 32'd1);
    chk("rst_r0_addr", 32'(read_address), 32'd1);
    tick();
    chk("rst_r0_rsp", 32'(rsp_valid), 32'd1);
    tick();
    chk("rst_idle", 32'(rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
